// File: rtl/dcdl_coarse_ctrl.sv
// Coarse DCDL control: accepts a binary code and ramps the thermometer bus toward it
// one cell at a time, dwelling STEP_CYCLES clocks per step. Freeze pauses the ramp.
module dcdl_coarse_ctrl #(
    parameter int N_THM       = 31,
    parameter int CODE_W      = 5,
    parameter int STEP_CYCLES = 4,
    parameter int RESET_CODE  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic              freeze,
    output logic [N_THM-1:0]  thm,
    output logic [CODE_W-1:0] cur_code,
    output logic              busy,
    output logic              done
);

    localparam int DW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [DW-1:0]     DWELL_RELOAD = DW'(STEP_CYCLES - 1);
    localparam logic [CODE_W-1:0] RST_CODE     = CODE_W'(RESET_CODE);
    localparam logic [CODE_W-1:0] MAX_CODE     = CODE_W'(N_THM);

    typedef enum logic [0:0] {IDLE, RAMP} state_t;

    state_t            state_q, state_d;
    logic [CODE_W-1:0] cur_q, cur_d;
    logic [CODE_W-1:0] tgt_q, tgt_d;
    logic [DW-1:0]     dwell_q, dwell_d;
    logic [N_THM-1:0]  thm_q;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CODE_W-1:0] code_clamped;

    function automatic logic [N_THM-1:0] therm(input logic [CODE_W-1:0] c);
        logic [N_THM-1:0] t;
        t = '0;
        for (int i = 0; i < N_THM; i++) begin
            t[i] = (i < int'(c));
        end
        return t;
    endfunction

    assign code_clamped = (code_in > MAX_CODE) ? MAX_CODE : code_in;
    assign code_ready   = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        dwell_d = dwell_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (code_valid) begin
                    tgt_d = code_clamped;
                    if (code_clamped == cur_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RAMP;
                        busy_d  = 1'b1;
                        dwell_d = DWELL_RELOAD;
                    end
                end
            end
            RAMP: begin
                if (!freeze) begin
                    if (dwell_q != '0) begin
                        dwell_d = dwell_q - 1'b1;
                    end else begin
                        // One cell per step keeps the delay line free of multi-bit code jumps
                        dwell_d = DWELL_RELOAD;
                        cur_d   = (cur_q < tgt_q) ? cur_q + 1'b1 : cur_q - 1'b1;
                        if (cur_d == tgt_q) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= RST_CODE;
            tgt_q   <= RST_CODE;
            dwell_q <= '0;
            thm_q   <= therm(RST_CODE);
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            dwell_q <= dwell_d;
            thm_q   <= therm(cur_d);
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign thm      = thm_q;
    assign cur_code = cur_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_dcdl_coarse_ctrl.sv
// Directed bench for dcdl_coarse_ctrl: table of ramp requests plus reset/clamp sequences,
// with a per-cycle thermometer/popcount/Hamming monitor.
module tb_dcdl_coarse_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  code_in;
    logic        code_valid;
    logic        code_ready;
    logic        freeze;
    logic [30:0] thm;
    logic [4:0]  cur_code;
    logic        busy;
    logic        done;

    logic        rst2;
    logic [4:0]  code_in2;
    logic        code_valid2;
    logic        code_ready2;
    logic        freeze2;
    logic [19:0] thm2;
    logic [4:0]  cur_code2;
    logic        busy2;
    logic        done2;

    int n_cmp = 0;
    int n_err = 0;
    int model_cur = 0;

    dcdl_coarse_ctrl #(.N_THM(31), .CODE_W(5), .STEP_CYCLES(4), .RESET_CODE(0)) dut (
        .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
        .code_ready(code_ready), .freeze(freeze), .thm(thm), .cur_code(cur_code),
        .busy(busy), .done(done)
    );

    dcdl_coarse_ctrl #(.N_THM(20), .CODE_W(5), .STEP_CYCLES(1), .RESET_CODE(0)) dut20 (
        .clk(clk), .rst(rst2), .code_in(code_in2), .code_valid(code_valid2),
        .code_ready(code_ready2), .freeze(freeze2), .thm(thm2), .cur_code(cur_code2),
        .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] code;
        logic       hold;
        logic [4:0] hold_code;
        int         frz_at;
        int         frz_len;
        int         exp_cur;
        int         exp_lat;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [63:0] therm64(input int c);
        return (64'd1 << c) - 64'd1;
    endfunction

    // Per-cycle structural checks on the 31-cell bus
    logic [30:0] prev_thm;
    bit          prev_ok = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_ok = 1'b0;
        end else begin
            chk("thm_is_thermometer", 64'((({33'd0, thm} + 64'd1) & {33'd0, thm}) == 64'd0), 64'd1);
            chk("popcount_eq_cur", 64'($countones(thm)), 64'(cur_code));
            if (prev_ok) chk("hamming_le_1", 64'($countones(thm ^ prev_thm) <= 1), 64'd1);
            prev_thm = thm;
            prev_ok  = 1'b1;
        end
    end

    task automatic run_row(input int idx, input vec_t v);
        int n;
        int n_eff;
        int dir;
        int exp;
        dir = (v.exp_cur > model_cur) ? 1 : ((v.exp_cur < model_cur) ? -1 : 0);
        code_in    = v.code;
        code_valid = 1'b1;
        tick();
        code_valid = v.hold;
        code_in    = v.hold_code;
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            if (n == v.frz_at) freeze = 1'b1;
            if (n == v.frz_at + v.frz_len) freeze = 1'b0;
            if (n <= v.frz_at)                  n_eff = n;
            else if (n <= v.frz_at + v.frz_len) n_eff = v.frz_at;
            else                                n_eff = n - v.frz_len;
            exp = model_cur + dir * (n_eff / 4);
            chk($sformatf("row%0d_cur_n%0d", idx, n), 64'(cur_code), 64'(exp));
            chk($sformatf("row%0d_thm_n%0d", idx, n), 64'(thm), therm64(exp));
            chk($sformatf("row%0d_busy_n%0d", idx, n), 64'(busy), 64'd1);
            chk($sformatf("row%0d_ready_n%0d", idx, n), 64'(code_ready), 64'd0);
            tick();
            n++;
        end
        code_valid = 1'b0;
        freeze     = 1'b0;
        chk($sformatf("row%0d_latency", idx), 64'(n), 64'(v.exp_lat));
        chk($sformatf("row%0d_final_cur", idx), 64'(cur_code), 64'(v.exp_cur));
        chk($sformatf("row%0d_final_thm", idx), 64'(thm), therm64(v.exp_cur));
        chk($sformatf("row%0d_busy_at_done", idx), 64'(busy), 64'd0);
        chk($sformatf("row%0d_ready_at_done", idx), 64'(code_ready), 64'd1);
        tick();
        chk($sformatf("row%0d_done_one_cycle", idx), 64'(done), 64'd0);
        model_cur = v.exp_cur;
    endtask

    initial begin
        int n;
        rst = 1'b1; code_in = '0; code_valid = 1'b0; freeze = 1'b0;
        rst2 = 1'b1; code_in2 = '0; code_valid2 = 1'b0; freeze2 = 1'b0;

        //         code  hold hcode frz_at frz_len exp_cur exp_lat
        vt[0]  = '{5'd5,  1'b0, 5'd0, 10000, 0, 5,  20};
        vt[1]  = '{5'd5,  1'b0, 5'd0, 10000, 0, 5,  0};
        vt[2]  = '{5'd2,  1'b0, 5'd0, 10000, 0, 2,  12};
        vt[3]  = '{5'd31, 1'b0, 5'd0, 10000, 0, 31, 116};
        vt[4]  = '{5'd28, 1'b0, 5'd0, 10000, 0, 28, 12};
        vt[5]  = '{5'd0,  1'b0, 5'd0, 10000, 0, 0,  112};
        vt[6]  = '{5'd0,  1'b0, 5'd0, 10000, 0, 0,  0};
        vt[7]  = '{5'd10, 1'b1, 5'd3, 10000, 0, 10, 40};
        vt[8]  = '{5'd0,  1'b0, 5'd0, 10000, 0, 0,  40};
        vt[9]  = '{5'd8,  1'b0, 5'd0, 12,    7, 8,  39};
        vt[10] = '{5'd0,  1'b0, 5'd0, 10000, 0, 0,  32};

        @(negedge clk);
        chk("rst_thm", 64'(thm), 64'd0);
        chk("rst_cur", 64'(cur_code), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ready", 64'(code_ready), 64'd1);
        #2;
        rst = 1'b0;
        rst2 = 1'b0;
        repeat (3) tick();
        chk("idle_hold_thm", 64'(thm), 64'd0);
        chk("idle_hold_cur", 64'(cur_code), 64'd0);
        chk("idle_hold_busy", 64'(busy), 64'd0);
        chk("idle_hold_done", 64'(done), 64'd0);

        for (int i = 0; i < 11; i++) run_row(i, vt[i]);

        // Asynchronous reset in the middle of a 0->20 ramp
        code_in = 5'd20; code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        repeat (10) tick();
        chk("midramp_cur_before_rst", 64'(cur_code), 64'd2);
        chk("midramp_busy_before_rst", 64'(busy), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("midramp_rst_thm", 64'(thm), 64'd0);
        chk("midramp_rst_cur", 64'(cur_code), 64'd0);
        chk("midramp_rst_busy", 64'(busy), 64'd0);
        chk("midramp_rst_ready", 64'(code_ready), 64'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (2) tick();
        chk("post_rst_cur", 64'(cur_code), 64'd0);
        chk("post_rst_done", 64'(done), 64'd0);

        // Clamp on the 20-cell, one-step-per-edge instance
        code_in2 = 5'd31; code_valid2 = 1'b1;
        tick();
        code_valid2 = 1'b0;
        n = 0;
        while (done2 !== 1'b1 && n < 100) begin
            chk($sformatf("clamp_cur_n%0d", n), 64'(cur_code2), 64'(n));
            tick();
            n++;
        end
        chk("clamp_latency", 64'(n), 64'd20);
        chk("clamp_cur", 64'(cur_code2), 64'd20);
        chk("clamp_thm", 64'(thm2), 64'hFFFFF);
        chk("clamp_busy", 64'(busy2), 64'd0);
        chk("clamp_ready", 64'(code_ready2), 64'd1);
        repeat (3) tick();
        chk("clamp_stays", 64'(cur_code2), 64'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
